memory_cycle: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline.
- Takes the EX/MEM-latched ALU result, store data and control, and performs byte/half/word loads and stores against an internal synchronous data memory.
- Registers the MEM/WB pipeline boundary that feeds writeback_cycle.
- Handles stall/flush from the hazard unit and flags misaligned accesses.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/memory_cycle_if.sv | 32 +++
 rtl/data_memory.sv | 18 +
 rtl/memory_cycle.sv | 53 +++++
 tb/tb_memory_cycle.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size encodings, MEM/WB record and byte-lane enable helper.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef struct packed {
    logic        regwrite;
    logic        isload;
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic [31:0] aluresult;
    logic [31:0] readdata;
  } mem_wb_t;
  // Reserved size 2'b11 falls through to the word case.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: EX/MEM-side inputs and MEM/WB-side outputs of the MEM stage.
interface memory_cycle_if;
  logic        stallM;
  logic        flushM;
  logic        regwriteM;
  logic        isloadM;
  logic        memwriteM;
  logic [1:0]  memsizeM;
  logic        memunsignedM;
  logic [4:0]  rdM;
  logic [31:0] pcplus4M;
  logic [31:0] aluresultM;
  logic [31:0] writedataM;
  logic        misalignM;
  logic        regwriteW;
  logic        isloadW;
  logic [4:0]  rdW;
  logic [31:0] pcplus4W;
  logic [31:0] aluresultW;
  logic [31:0] readdataW;
  logic        excW;
  modport master (
    output stallM, flushM, regwriteM, isloadM, memwriteM, memsizeM, memunsignedM,
           rdM, pcplus4M, aluresultM, writedataM,
    input  misalignM, regwriteW, isloadW, rdW, pcplus4W, aluresultW, readdataW, excW
  );
  modport slave (
    input  stallM, flushM, regwriteM, isloadM, memwriteM, memsizeM, memunsignedM,
           rdM, pcplus4M, aluresultM, writedataM,
    output misalignM, regwriteW, isloadW, rdW, pcplus4W, aluresultW, readdataW, excW
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: word array with per-byte write enables, synchronous write, combinational read.
module data_memory #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [MEM_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: MIPS MEM stage -- byte/half/word load/store, misalign detection, MEM/WB register.
module memory_cycle
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input logic          clk,
  input logic          rst,
  memory_cycle_if.slave bus
);
  logic [1:0]  off;
  logic [ADDR_W-1:0] widx;
  logic        is_half, is_word, misalign, we, sx;
  logic [31:0] rword, wlanes, shifted, ext;
  mem_wb_t     wb_d, wb_q;
  assign off  = bus.aluresultM[1:0];
  assign widx = bus.aluresultM[ADDR_W+1:2];
  data_memory #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_dmem (
    .clk(clk), .we(we), .be(byte_en(bus.memsizeM, off)), .addr(widx), .wdata(wlanes), .rdata(rword)
  );
  always_comb begin
    is_half  = bus.memsizeM == SZ_HALF;
    is_word  = bus.memsizeM[1];
    misalign = (bus.isloadM | bus.memwriteM) & ((is_half & off[0]) | (is_word & |off));
    we       = bus.memwriteM & ~misalign & ~bus.stallM & ~bus.flushM & rst;
    // Replicate store data so every enabled lane sees the right-aligned bytes.
    wlanes   = bus.memsizeM == SZ_BYTE ? {4{bus.writedataM[7:0]}} : is_half ? {2{bus.writedataM[15:0]}} : bus.writedataM;
    shifted  = rword >> {off, 3'b000};
    sx       = ~bus.memunsignedM;
    ext      = bus.memsizeM == SZ_BYTE ? {{24{sx & shifted[7]}}, shifted[7:0]}
             : is_half ? {{16{sx & shifted[15]}}, shifted[15:0]} : rword;
    wb_d     = bus.flushM ? '0 : bus.stallM ? wb_q : mem_wb_t'{
                 regwrite:  bus.regwriteM & ~misalign,
                 isload:    bus.isloadM,
                 exc:       misalign,
                 rd:        bus.rdM,
                 pcplus4:   bus.pcplus4M,
                 aluresult: bus.aluresultM,
                 readdata:  ext};
  end
  always_ff @(posedge clk)
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  assign bus.misalignM  = misalign;
  assign bus.regwriteW  = wb_q.regwrite;
  assign bus.isloadW    = wb_q.isload;
  assign bus.excW       = wb_q.exc;
  assign bus.rdW        = wb_q.rd;
  assign bus.pcplus4W   = wb_q.pcplus4;
  assign bus.aluresultW = wb_q.aluresult;
  assign bus.readdataW  = wb_q.readdata;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed and randomized checks of memory_cycle against a byte-array model.
module tb_memory_cycle;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  memory_cycle_if bus();
  memory_cycle #(.MEM_WORDS(1024), .ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0]  mb [4096];
  logic        e_rw, e_ld, e_exc, e_mis, e_known;
  logic [4:0]  e_rd;
  logic [31:0] e_pc, e_alu, e_data;

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz, input bit un);
    int n;
    int b;
    logic [31:0] v;
    n = nbytes(sz);
    b = int'(a % 4096);
    v = 0;
    for (int k = 0; k < n; k++) v |= 32'(mb[(b + k) % 4096]) << (8 * k);
    if (!un && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic op(input bit st, input bit fl, input bit rw, input bit ld, input bit wr,
                    input logic [1:0] sz, input bit un, input logic [4:0] rd,
                    input logic [31:0] pc, input logic [31:0] a, input logic [31:0] wd);
    int  n;
    bit  mis;
    n = nbytes(sz);
    bus.stallM = st; bus.flushM = fl; bus.regwriteM = rw; bus.isloadM = ld; bus.memwriteM = wr;
    bus.memsizeM = sz; bus.memunsignedM = un; bus.rdM = rd; bus.pcplus4M = pc;
    bus.aluresultM = a; bus.writedataM = wd;
    mis = (ld | wr) && (a % n != 0);
    e_mis = mis;
    if (fl) begin
      e_rw = 0; e_ld = 0; e_exc = 0; e_rd = 0; e_pc = 0; e_alu = 0; e_data = 0; e_known = 1;
    end else if (!st) begin
      e_rw = rw & ~mis; e_ld = ld; e_exc = mis; e_rd = rd; e_pc = pc; e_alu = a;
      e_known = (a % n == 0);
      e_data = model_read(a, sz, un);
    end
    if (wr && !mis && !st && !fl)
      for (int k = 0; k < n; k++) mb[(int'(a % 4096) + k) % 4096] = wd[8*k +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sz, input bit un, input logic [31:0] a);
    op(0, 0, 1, 1, 0, sz, un, 5'($urandom), $urandom, a, $urandom);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    op(0, 0, 0, 0, 1, sz, 0, 5'($urandom), $urandom, a, wd);
  endtask

  task automatic test_reset;
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      bus.stallM = 1'($urandom); bus.flushM = 1'($urandom); bus.regwriteM = 1'($urandom);
      bus.isloadM = 1'($urandom); bus.memwriteM = 1'($urandom); bus.memsizeM = 2'($urandom);
      bus.memunsignedM = 1'($urandom); bus.rdM = 5'($urandom); bus.pcplus4M = $urandom;
      bus.aluresultM = $urandom; bus.writedataM = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.regwriteW, bus.isloadW, bus.excW, bus.rdW, bus.pcplus4W, bus.aluresultW, bus.readdataW} !== '0)
        begin errors++; $display("FAIL reset_w_zero cycle %0d: rw=%b ld=%b exc=%b rd=%h pc=%h alu=%h data=%h, expected all zero",
          i, bus.regwriteW, bus.isloadW, bus.excW, bus.rdW, bus.pcplus4W, bus.aluresultW, bus.readdataW); end
    end
    rst = 1;
    store(2'b10, 32'h10, 32'hDEADBEEF);
    load(2'b10, 0, 32'h10);
    checks++;
    if (bus.readdataW !== 32'hDEADBEEF || bus.isloadW !== 1'b1)
      begin errors++; $display("FAIL reset_then_lw data=%h isload=%b, expected deadbeef/1", bus.readdataW, bus.isloadW); end
  endtask

  task automatic init_mem;
    for (int i = 0; i < 1024; i++) store(2'b10, 32'(i * 4), 32'h0);
  endtask

  task automatic test_lanes;
    store(2'b10, 32'h20, 32'h11223344);
    store(2'b00, 32'h21, 32'h000000AA);
    load(2'b10, 0, 32'h20);
    checks++;
    if (bus.readdataW !== 32'h1122AA44) begin errors++; $display("FAIL lanes_lw got=%h expected=1122aa44", bus.readdataW); end
    load(2'b00, 0, 32'h21);
    checks++;
    if (bus.readdataW !== 32'hFFFFFFAA) begin errors++; $display("FAIL lanes_lb got=%h expected=ffffffaa", bus.readdataW); end
    load(2'b00, 1, 32'h21);
    checks++;
    if (bus.readdataW !== 32'h000000AA) begin errors++; $display("FAIL lanes_lbu got=%h expected=000000aa", bus.readdataW); end
    load(2'b01, 0, 32'h22);
    checks++;
    if (bus.readdataW !== 32'h00001122) begin errors++; $display("FAIL lanes_lh got=%h expected=00001122", bus.readdataW); end
    load(2'b11, 0, 32'h20);
    checks++;
    if (bus.readdataW !== 32'h1122AA44) begin errors++; $display("FAIL lanes_size11 got=%h expected=1122aa44", bus.readdataW); end
  endtask

  task automatic test_misalign;
    store(2'b01, 32'h31, 32'h0000BEEF);
    checks++;
    if (bus.misalignM !== 1'b1 || bus.excW !== 1'b1)
      begin errors++; $display("FAIL misalign_sh misalignM=%b excW=%b expected 1/1", bus.misalignM, bus.excW); end
    load(2'b10, 0, 32'h30);
    checks++;
    if (bus.readdataW !== 32'h0 || bus.excW !== 1'b0)
      begin errors++; $display("FAIL misalign_mem_kept data=%h exc=%b expected 0/0", bus.readdataW, bus.excW); end
    op(0, 0, 1, 1, 0, 2'b10, 0, 5'd9, 32'h44, 32'h32, 32'h0);
    checks++;
    if (bus.regwriteW !== 1'b0 || bus.excW !== 1'b1 || bus.rdW !== 5'd9)
      begin errors++; $display("FAIL misalign_lw rw=%b exc=%b rd=%0d expected 0/1/9", bus.regwriteW, bus.excW, bus.rdW); end
    load(2'b10, 0, 32'h30);
    checks++;
    if (bus.excW !== 1'b0 || bus.regwriteW !== 1'b1)
      begin errors++; $display("FAIL misalign_one_cycle exc=%b rw=%b expected 0/1", bus.excW, bus.regwriteW); end
  endtask

  task automatic test_stall;
    load(2'b10, 0, 32'h20);
    checks++;
    if (bus.readdataW !== 32'h1122AA44) begin errors++; $display("FAIL stall_pre got=%h expected=1122aa44", bus.readdataW); end
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 1, 0, 1, 2'b10, 0, 5'd3, 32'h99, 32'h20, 32'h55);
      checks++;
      if ({bus.regwriteW, bus.isloadW, bus.excW, bus.rdW, bus.pcplus4W, bus.aluresultW, bus.readdataW} !==
          {e_rw, e_ld, e_exc, e_rd, e_pc, e_alu, 32'h1122AA44})
        begin errors++; $display("FAIL stall_hold cycle %0d: rd=%0d pc=%h alu=%h data=%h expected rd=%0d pc=%h alu=%h data=1122aa44",
          i, bus.rdW, bus.pcplus4W, bus.aluresultW, bus.readdataW, e_rd, e_pc, e_alu); end
    end
    load(2'b10, 0, 32'h20);
    checks++;
    if (bus.readdataW !== 32'h1122AA44) begin errors++; $display("FAIL stall_no_store got=%h expected=1122aa44", bus.readdataW); end
  endtask

  task automatic test_flush;
    op(0, 0, 1, 1, 0, 2'b10, 0, 5'd7, 32'h100, 32'h20, 32'h0);
    op(1, 1, 1, 1, 0, 2'b10, 0, 5'd8, 32'h104, 32'h20, 32'h0);
    checks++;
    if (bus.regwriteW !== 1'b0 || bus.isloadW !== 1'b0 || bus.rdW !== 5'd0 || bus.excW !== 1'b0)
      begin errors++; $display("FAIL flush_bubble rw=%b ld=%b rd=%0d exc=%b expected all 0", bus.regwriteW, bus.isloadW, bus.rdW, bus.excW); end
    op(0, 1, 0, 0, 1, 2'b10, 0, 5'd0, 32'h0, 32'h40, 32'h77);
    load(2'b10, 0, 32'h40);
    checks++;
    if (bus.readdataW !== 32'h0) begin errors++; $display("FAIL flush_no_store got=%h expected=00000000", bus.readdataW); end
  endtask

  task automatic test_wrap;
    store(2'b10, 32'h1000, 32'hCAFE0001);
    load(2'b10, 0, 32'h0);
    checks++;
    if (bus.readdataW !== 32'hCAFE0001) begin errors++; $display("FAIL wrap got=%h expected=cafe0001", bus.readdataW); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      bit wr;
      wr = 1'($urandom);
      op($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'($urandom), ~wr & 1'($urandom), wr,
         2'($urandom), 1'($urandom), 5'($urandom), $urandom,
         ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127)), $urandom);
      checks++;
      if (bus.misalignM !== e_mis) begin errors++; $display("FAIL rand_misalign #%0d got=%b expected=%b", i, bus.misalignM, e_mis); end
      checks++;
      if ({bus.regwriteW, bus.isloadW, bus.excW, bus.rdW, bus.pcplus4W, bus.aluresultW} !==
          {e_rw, e_ld, e_exc, e_rd, e_pc, e_alu})
        begin errors++; $display("FAIL rand_ctrl #%0d got rw=%b ld=%b exc=%b rd=%0d pc=%h alu=%h expected rw=%b ld=%b exc=%b rd=%0d pc=%h alu=%h",
          i, bus.regwriteW, bus.isloadW, bus.excW, bus.rdW, bus.pcplus4W, bus.aluresultW, e_rw, e_ld, e_exc, e_rd, e_pc, e_alu); end
      if (e_known) begin
        checks++;
        if (bus.readdataW !== e_data) begin errors++; $display("FAIL rand_data #%0d got=%h expected=%h", i, bus.readdataW, e_data); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    init_mem();
    test_lanes();
    test_misalign();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
